// File: rtl/aquarius_joy_pkg.sv
// Shared joystick definitions for the conditioner and its per-player channels.
package aquarius_joy_pkg;

    // One player's joystick word, active-high {Y,X,B,A,up,down,left,right}
    typedef logic [7:0] joy_t;

    localparam int unsigned JOY_RIGHT = 0;
    localparam int unsigned JOY_LEFT  = 1;
    localparam int unsigned JOY_DOWN  = 2;
    localparam int unsigned JOY_UP    = 3;
    localparam int unsigned JOY_A     = 4;
    localparam int unsigned JOY_B     = 5;
    localparam int unsigned JOY_X     = 6;
    localparam int unsigned JOY_Y     = 7;

    // Buttons A,B,X,Y are the autofire candidates by default
    localparam joy_t AF_MASK_DEFAULT = 8'hF0;

    // True when any masked (fire) bit is held
    function automatic logic any_masked(input joy_t j, input joy_t mask);
        return |(j & mask);
    endfunction

endpackage

// File: rtl/joy_channel.sv
// One player's path: 2-flop sync, per-bit tick debounce, autofire, registered output and change pulse.
module joy_channel
    import aquarius_joy_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned AUTOFIRE_TICKS = 50,
    parameter logic [7:0]  AF_MASK        = AF_MASK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [7:0] joy_in,
    input  logic       af_en,
    output logic [7:0] joy_out,
    output logic       chg
);

    localparam int unsigned DbW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam int unsigned AfW = (AUTOFIRE_TICKS > 1) ? $clog2(AUTOFIRE_TICKS) : 1;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_TICKS - 1);
    localparam logic [AfW-1:0] AfLast = AfW'(AUTOFIRE_TICKS - 1);

    joy_t                sync1_q, sync1_d, sync2_q, sync2_d;
    joy_t                stable_q, stable_d;
    logic [7:0][DbW-1:0] db_cnt_q, db_cnt_d;
    logic [AfW-1:0]      af_cnt_q, af_cnt_d;
    logic                af_phase_q, af_phase_d;
    joy_t                joy_out_q, joy_out_d;
    logic                chg_q, chg_d;
    logic                af_active;

    // Next-state: synchroniser, debounce, autofire and output/change registers
    always_comb begin
        sync1_d  = joy_in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        for (int b = 0; b < 8; b++) begin
            // Agreement clears the count even on a tick; only a continuous mismatch accumulates
            if (sync2_q[b] == stable_q[b]) begin
                db_cnt_d[b] = '0;
            end else if (tick) begin
                if (db_cnt_q[b] == DbLast) begin
                    stable_d[b] = sync2_q[b];
                    db_cnt_d[b] = '0;
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + 1'b1;
                end
            end
        end

        af_active  = af_en & any_masked(stable_q, AF_MASK);
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (!af_active) begin
            // Phase parks "on" so the first press fires at once
            af_cnt_d   = '0;
            af_phase_d = 1'b1;
        end else if (tick) begin
            if (af_cnt_q == AfLast) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 1'b1;
            end
        end

        // af_en gates directly so dropping it restores the held buttons on the next cycle
        joy_out_d = stable_q & ((af_phase_q || !af_en) ? 8'hFF : ~AF_MASK);
        chg_d     = (joy_out_d != joy_out_q);
    end

    // State registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            db_cnt_q   <= '0;
            af_cnt_q   <= '0;
            af_phase_q <= 1'b1;
            joy_out_q  <= '0;
            chg_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            db_cnt_q   <= db_cnt_d;
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            joy_out_q  <= joy_out_d;
            chg_q      <= chg_d;
        end
    end

    assign joy_out = joy_out_q;
    assign chg     = chg_q;

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner: shared debounce/autofire tick divider feeding two independent channels.
module joy_conditioner
    import aquarius_joy_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 3580,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned AUTOFIRE_TICKS = 50,
    parameter logic [7:0]  AF_MASK        = AF_MASK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] joy0_in,
    input  logic [7:0] joy1_in,
    input  logic [1:0] autofire_en,
    output logic [7:0] joy0_out,
    output logic [7:0] joy1_out,
    output logic       joy0_chg,
    output logic       joy1_chg
);

    localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);

    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    // Free-running divider; tick marks the last count before wrap
    always_comb begin
        tick       = (tick_cnt_q == TickLast);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    // Divider register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    joy_channel #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .AUTOFIRE_TICKS (AUTOFIRE_TICKS),
        .AF_MASK        (AF_MASK)
    ) u_chan0 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .joy_in  (joy0_in),
        .af_en   (autofire_en[0]),
        .joy_out (joy0_out),
        .chg     (joy0_chg)
    );

    joy_channel #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .AUTOFIRE_TICKS (AUTOFIRE_TICKS),
        .AF_MASK        (AF_MASK)
    ) u_chan1 (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .joy_in  (joy1_in),
        .af_en   (autofire_en[1]),
        .joy_out (joy1_out),
        .chg     (joy1_chg)
    );

endmodule

// File: tb/tb_joy_conditioner.sv
// Bench for joy_conditioner: directed scenarios plus random stimulus against a behavioural model.
module tb_joy_conditioner;

    localparam int TD  = 4;
    localparam int DB  = 3;
    localparam int AFT = 2;
    localparam logic [7:0] MASK = 8'hF0;

    logic       clk;
    logic       reset;
    logic [7:0] joy0_in, joy1_in;
    logic [1:0] autofire_en;
    logic [7:0] joy0_out, joy1_out;
    logic       joy0_chg, joy1_chg;

    int n_tests = 0;
    int n_fail  = 0;

    joy_conditioner #(
        .TICK_DIV       (TD),
        .DEBOUNCE_TICKS (DB),
        .AUTOFIRE_TICKS (AFT),
        .AF_MASK        (MASK)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy0_in     (joy0_in),
        .joy1_in     (joy1_in),
        .autofire_en (autofire_en),
        .joy0_out    (joy0_out),
        .joy1_out    (joy1_out),
        .joy0_chg    (joy0_chg),
        .joy1_chg    (joy1_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Cycle count since reset gives tick position; debounce is "DB consecutive ticks of
    // disagreement"; autofire phase is derived from ticks spent active.
    logic [7:0] m_pipe0 [2];
    logic [7:0] m_pipe1 [2];
    logic [7:0] m_stable[2];
    logic [7:0] m_out   [2];
    logic       m_chg   [2];
    int         m_run   [2][8];
    int         m_act   [2];
    int         m_cyc;

    task automatic m_reset();
        m_cyc = 0;
        for (int p = 0; p < 2; p++) begin
            m_pipe0[p] = 8'h00; m_pipe1[p] = 8'h00; m_stable[p] = 8'h00;
            m_out[p] = 8'h00; m_chg[p] = 1'b0; m_act[p] = 0;
            for (int b = 0; b < 8; b++) m_run[p][b] = 0;
        end
    endtask

    // Predicts the state after the next rising edge from the inputs held now
    task automatic m_step();
        logic       tk;
        logic       en;
        logic [7:0] nxt;
        logic [7:0] inp[2];
        tk = (m_cyc % TD) == TD - 1;
        inp[0] = joy0_in;
        inp[1] = joy1_in;
        for (int p = 0; p < 2; p++) begin
            en  = autofire_en[p];
            nxt = m_stable[p];
            if (en && ((m_act[p] / AFT) % 2) == 1) nxt = nxt & ~MASK;
            m_chg[p] = (nxt != m_out[p]);
            m_out[p] = nxt;
            if (en && (m_stable[p] & MASK) != 8'h00) begin
                if (tk) m_act[p]++;
            end else begin
                m_act[p] = 0;
            end
            for (int b = 0; b < 8; b++) begin
                if (m_pipe1[p][b] != m_stable[p][b]) begin
                    if (tk) begin
                        m_run[p][b]++;
                        if (m_run[p][b] == DB) begin
                            m_stable[p][b] = m_pipe1[p][b];
                            m_run[p][b] = 0;
                        end
                    end
                end else begin
                    m_run[p][b] = 0;
                end
            end
            m_pipe1[p] = m_pipe0[p];
            m_pipe0[p] = inp[p];
        end
        m_cyc++;
    endtask

    // Compare on every falling edge, then advance the model
    initial begin
        forever begin
            @(negedge clk);
            if (reset) m_reset();
            check8("model joy0_out", joy0_out, m_out[0]);
            check8("model joy1_out", joy1_out, m_out[1]);
            check8("model joy0_chg", {7'b0, joy0_chg}, {7'b0, m_chg[0]});
            check8("model joy1_chg", {7'b0, joy1_chg}, {7'b0, m_chg[1]});
            if (!reset) m_step();
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_pulse();
        reset = 1'b1;
        joy0_in = 8'h00; joy1_in = 8'h00; autofire_en = 2'b00;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic wait_out0(input logic [7:0] v, input int budget, input string name);
        int i;
        i = 0;
        while (joy0_out !== v && i < budget) begin
            cyc(1);
            i++;
        end
        check8(name, joy0_out, v);
    endtask

    int pulses0, pulses1, both_same, seen;

    initial begin
        reset = 1'b1;
        joy0_in = 8'hFF; joy1_in = 8'hFF; autofire_en = 2'b11;

        // 1: reset with all inputs high
        cyc(3);
        check8("t1 reset joy0", joy0_out, 8'h00);
        check8("t1 reset joy1", joy1_out, 8'h00);
        check8("t1 reset chg", {6'b0, joy0_chg, joy1_chg}, 8'h00);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            check8("t1 post-reset", joy0_out | joy1_out, 8'h00);
        end

        // 2: glitch shorter than the debounce window
        rst_pulse();
        joy0_in = 8'h01;
        cyc(8);
        joy0_in = 8'h00;
        pulses0 = 0; seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (joy0_chg) pulses0++;
            if (joy0_out != 8'h00) seen++;
        end
        check8("t2 glitch out", 8'(seen), 8'h00);
        check8("t2 glitch chg", 8'(pulses0), 8'h00);

        // 3: press and release
        joy0_in = 8'h01;
        pulses0 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (joy0_chg) pulses0++;
        end
        check8("t3 press out", joy0_out, 8'h01);
        check8("t3 press chg", 8'(pulses0), 8'h01);
        joy0_in = 8'h00;
        pulses0 = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (joy0_chg) pulses0++;
        end
        check8("t3 release out", joy0_out, 8'h00);
        check8("t3 release chg", 8'(pulses0), 8'h01);

        // 4: autofire on player 0 only
        rst_pulse();
        autofire_en = 2'b01;
        joy0_in = 8'h10; joy1_in = 8'h10;
        wait_out0(8'h10, 20, "t4 first fire");
        cyc(7);
        check8("t4 still on", joy0_out, 8'h10);
        cyc(1);
        check8("t4 off", joy0_out, 8'h00);
        check8("t4 p1 steady", joy1_out, 8'h10);
        cyc(8);
        check8("t4 on again", joy0_out, 8'h10);
        check8("t4 p1 steady2", joy1_out, 8'h10);

        // 5: direction unaffected, autofire dropped mid-burst
        rst_pulse();
        autofire_en = 2'b01;
        joy0_in = 8'h11;
        wait_out0(8'h11, 20, "t5 first");
        wait_out0(8'h01, 12, "t5 off phase");
        autofire_en = 2'b00;
        cyc(1);
        check8("t5 af dropped", joy0_out, 8'h11);

        // 6: reset during burst, then re-debounce with input held
        rst_pulse();
        autofire_en = 2'b01;
        joy0_in = 8'h10;
        wait_out0(8'h10, 20, "t6 firing");
        cyc(2);
        reset = 1'b1;
        #1;
        check8("t6 async reset", joy0_out, 8'h00);
        check8("t6 async chg", {7'b0, joy0_chg}, 8'h00);
        cyc(2);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (joy0_out != 8'h00) seen++;
        end
        check8("t6 redebounce", 8'(seen), 8'h00);
        begin
            int i;
            i = 0;
            while (joy0_out == 8'h00 && i < 20) begin
                cyc(1);
                i++;
            end
        end
        check8("t6 first phase on", joy0_out, 8'h10);

        // 7: opposing directions on both players at once
        rst_pulse();
        joy0_in = 8'h0C; joy1_in = 8'h0C;
        pulses0 = 0; pulses1 = 0; both_same = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (joy0_chg) pulses0++;
            if (joy1_chg) pulses1++;
            if (joy0_chg && joy1_chg) both_same++;
        end
        check8("t7 joy0", joy0_out, 8'h0C);
        check8("t7 joy1", joy1_out, 8'h0C);
        check8("t7 simultaneous chg", 8'(both_same), 8'h01);

        // Random stimulus, checked by the model every cycle
        rst_pulse();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 23) == 0) joy0_in = 8'($urandom);
            if ($urandom_range(0, 23) == 0) joy1_in = 8'($urandom);
            if ($urandom_range(0, 5) == 0) joy0_in[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 59) == 0) autofire_en = 2'($urandom);
            if (i == 1500) begin
                reset = 1'b1;
                cyc(2);
                reset = 1'b0;
            end
            cyc(1);
        end

        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
